// File: rtl/pong_vga_renderer.sv
// 640x480@60 VGA raster generator for the pong playfield: owns the timing
// counters, snapshots game coordinates once per frame and draws ball/paddles/net.
module pong_vga_renderer #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_W  = 8,
  parameter int PADDLE_H  = 64,
  parameter int PADDLE1_X = 16,
  parameter int PADDLE2_X = 616,
  parameter int COORD_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_ce,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] paddle1,
  input  logic [COORD_W-1:0] paddle2,
  input  logic [1:0]         game_state,
  output logic               hsync,
  output logic               vsync,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               frame_tick
);

  typedef enum logic [1:0] {
    NEW_GAME = 2'd0,
    PLAY     = 2'd1,
    NEW_BALL = 2'd2,
    OVER     = 2'd3
  } game_state_t;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_SNAP   = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [COORD_W-1:0] NET_L    = COORD_W'(H_ACTIVE / 2 - 2);
  localparam logic [COORD_W-1:0] NET_R    = COORD_W'(H_ACTIVE / 2 + 1);
  localparam logic [COORD_W-1:0] CNT_ONE  = COORD_W'(1);

  // Object extents are compared one bit wider so objects near the top of the
  // coordinate range get clipped instead of wrapping back onto row/column 0.
  localparam logic [COORD_W:0] BALL_EXT = (COORD_W+1)'(BALL_SIZE);
  localparam logic [COORD_W:0] PAD_H    = (COORD_W+1)'(PADDLE_H);
  localparam logic [COORD_W:0] PAD1_L   = (COORD_W+1)'(PADDLE1_X);
  localparam logic [COORD_W:0] PAD1_R   = (COORD_W+1)'(PADDLE1_X + PADDLE_W);
  localparam logic [COORD_W:0] PAD2_L   = (COORD_W+1)'(PADDLE2_X);
  localparam logic [COORD_W:0] PAD2_R   = (COORD_W+1)'(PADDLE2_X + PADDLE_W);

  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic [COORD_W-1:0] snap_ball_x, snap_ball_y, snap_paddle1, snap_paddle2;
  game_state_t        snap_state;

  logic [COORD_W:0] h_ext, v_ext;
  logic [COORD_W:0] ball_x_ext, ball_y_ext, pad1_y_ext, pad2_y_ext;
  logic             active, ball_on, pad1_on, pad2_on, net_on, snap_point;
  logic [11:0]      pix_rgb;

  assign h_ext      = {1'b0, h_cnt};
  assign v_ext      = {1'b0, v_cnt};
  assign ball_x_ext = {1'b0, snap_ball_x};
  assign ball_y_ext = {1'b0, snap_ball_y};
  assign pad1_y_ext = {1'b0, snap_paddle1};
  assign pad2_y_ext = {1'b0, snap_paddle2};
  assign snap_point = (h_cnt == H_LAST) && (v_cnt == V_SNAP);

  // Pixel colour for the current counter position, highest-priority object wins.
  always_comb begin
    pix_rgb = 12'h000;
    active  = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    ball_on = (snap_state != NEW_GAME)
              && (h_ext >= ball_x_ext) && (h_ext < ball_x_ext + BALL_EXT)
              && (v_ext >= ball_y_ext) && (v_ext < ball_y_ext + BALL_EXT);
    pad1_on = (h_ext >= PAD1_L) && (h_ext < PAD1_R)
              && (v_ext >= pad1_y_ext) && (v_ext < pad1_y_ext + PAD_H);
    pad2_on = (h_ext >= PAD2_L) && (h_ext < PAD2_R)
              && (v_ext >= pad2_y_ext) && (v_ext < pad2_y_ext + PAD_H);
    net_on  = (h_cnt >= NET_L) && (h_cnt <= NET_R) && !v_cnt[3];
    if (active) begin
      if (ball_on)
        pix_rgb = (snap_state == OVER) ? 12'hF00 : 12'hFFF;
      else if (pad1_on || pad2_on)
        pix_rgb = (snap_state == OVER) ? 12'hF00 : 12'h0FF;
      else if (net_on)
        pix_rgb = 12'h888;
    end
  end

  // Timing counters, registered sync/colour and the once-per-frame snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      vga_r        <= 4'h0;
      vga_g        <= 4'h0;
      vga_b        <= 4'h0;
      frame_tick   <= 1'b0;
      snap_ball_x  <= '0;
      snap_ball_y  <= '0;
      snap_paddle1 <= '0;
      snap_paddle2 <= '0;
      snap_state   <= NEW_GAME;
    end else begin
      frame_tick <= 1'b0;
      if (pix_ce) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_ONE;
        end else begin
          h_cnt <= h_cnt + CNT_ONE;
        end
        hsync <= !((h_cnt >= HS_START) && (h_cnt <= HS_END));
        vsync <= !((v_cnt >= VS_START) && (v_cnt <= VS_END));
        vga_r <= pix_rgb[11:8];
        vga_g <= pix_rgb[7:4];
        vga_b <= pix_rgb[3:0];
        if (snap_point) begin
          snap_ball_x  <= ball_x;
          snap_ball_y  <= ball_y;
          snap_paddle1 <= paddle1;
          snap_paddle2 <= paddle2;
          snap_state   <= game_state_t'(game_state);
          frame_tick   <= 1'b1;
        end
      end
    end
  end

endmodule
